// File: rtl/channel_lpf_fx.sv
// Fixed-point multi-lane, multi-pole IIR low-pass channel model with LFSR noise and output saturation.
// Latency: input sampled on a UI edge e reaches Data_out at edge e+POLES+1. There is no backpressure; one sample per cycle.
module channel_lpf_fx #(
    parameter int          LANES    = 1,
    parameter int          DATA_W   = 12,
    parameter int          COEF_W   = 16,
    parameter int          POLES    = 2,
    parameter int          OSR      = 10,
    parameter int          NOISE_W  = 4,
    parameter int unsigned BETA_RST = 12386
) (
    input  logic                    Sample_CLK,
    input  logic                    Rst_n,
    input  logic [LANES-1:0]        Data_in,
    input  logic [COEF_W-1:0]       Coef_in,
    input  logic                    Coef_wr,
    input  logic                    Noise_en,
    output logic [LANES*DATA_W-1:0] Data_out,
    output logic                    Data_valid,
    output logic                    Ui_strobe,
    output logic                    Coef_pend
);

    localparam int PH_W  = $clog2(OSR);
    localparam int ACC_W = DATA_W + COEF_W + 2;

    localparam logic signed [DATA_W-1:0] LVL_P  = {2'b01, {(DATA_W-2){1'b0}}};
    localparam logic signed [DATA_W-1:0] LVL_N  = {2'b11, {(DATA_W-2){1'b0}}};
    localparam logic signed [ACC_W-1:0]  HALF   = ACC_W'(2**(COEF_W-1));
    localparam logic signed [ACC_W-1:0]  SAT_HI = ACC_W'(2**(DATA_W-1) - 1);
    localparam logic signed [ACC_W-1:0]  SAT_LO = ~SAT_HI;

    function automatic logic signed [ACC_W-1:0] sx(input logic signed [DATA_W-1:0] v);
        return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] v);
        if (v > SAT_HI) begin
            return SAT_HI[DATA_W-1:0];
        end else if (v < SAT_LO) begin
            return SAT_LO[DATA_W-1:0];
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction

    logic [PH_W-1:0]   phase;
    logic              ui_edge;
    logic              commit_edge;
    logic [COEF_W-1:0] beta;
    logic [COEF_W-1:0] shadow;
    logic [2:0]        wcnt;

    assign ui_edge     = (phase == '0);
    assign commit_edge = (phase == PH_W'(OSR-1));
    assign Ui_strobe   = ui_edge;

    always_ff @(posedge Sample_CLK) begin
        if (!Rst_n) begin
            phase <= '0;
        end else if (commit_edge) begin
            phase <= '0;
        end else begin
            phase <= phase + PH_W'(1);
        end
    end

    // Writes land in the shadow; beta only moves on the last cycle of a UI so a UI is filtered with one coefficient.
    always_ff @(posedge Sample_CLK) begin
        if (!Rst_n) begin
            beta      <= COEF_W'(BETA_RST);
            shadow    <= COEF_W'(BETA_RST);
            Coef_pend <= 1'b0;
        end else begin
            if (Coef_wr) begin
                shadow <= Coef_in;
            end
            if (commit_edge) begin
                if (Coef_wr) begin
                    beta <= Coef_in;
                end else if (Coef_pend) begin
                    beta <= shadow;
                end
                Coef_pend <= 1'b0;
            end else if (Coef_wr) begin
                Coef_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge Sample_CLK) begin
        if (!Rst_n) begin
            wcnt       <= '0;
            Data_valid <= 1'b0;
        end else if (wcnt == 3'(POLES)) begin
            Data_valid <= 1'b1;
        end else begin
            wcnt <= wcnt + 3'd1;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam logic [15:0] SEED_X = 16'hACE1 ^ 16'(i * 16'h1D3);
        localparam logic [15:0] SEED   = (SEED_X == 16'h0000) ? 16'h0001 : SEED_X;

        logic signed [DATA_W-1:0]  u;
        logic signed [DATA_W-1:0]  y_arr [POLES];
        logic [15:0]               lfsr;
        logic signed [NOISE_W:0]   nz;
        logic signed [ACC_W-1:0]   nz_x;
        logic signed [ACC_W-1:0]   out_acc;
        logic signed [DATA_W-1:0]  out_q;

        always_ff @(posedge Sample_CLK) begin
            if (!Rst_n) begin
                u <= '0;
            end else if (ui_edge) begin
                u <= Data_in[i] ? LVL_P : LVL_N;
            end
        end

        for (genvar p = 0; p < POLES; p++) begin : g_stage
            logic signed [DATA_W-1:0] x;
            logic signed [DATA_W-1:0] y_q;
            logic signed [ACC_W-1:0]  diff;
            logic signed [ACC_W-1:0]  prod;
            logic signed [ACC_W-1:0]  nxt;

            if (p == 0) begin : g_first
                assign x = u;
            end else begin : g_rest
                assign x = y_arr[p-1];
            end

            // beta < 1 bounds the rounded step by |d|, so the state never overshoots its input.
            always_comb begin
                diff = sx(x) - sx(y_q);
                prod = diff * $signed({{(ACC_W-COEF_W){1'b0}}, beta});
                nxt  = sx(y_q) + ((prod + HALF) >>> COEF_W);
            end

            always_ff @(posedge Sample_CLK) begin
                if (!Rst_n) begin
                    y_q <= '0;
                end else begin
                    y_q <= sat(nxt);
                end
            end

            assign y_arr[p] = y_q;
        end

        always_ff @(posedge Sample_CLK) begin
            if (!Rst_n) begin
                lfsr <= SEED;
            end else if (Noise_en) begin
                lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            end
        end

        assign nz      = lfsr[NOISE_W:0];
        assign nz_x    = Noise_en ? {{(ACC_W-NOISE_W-1){nz[NOISE_W]}}, nz} : '0;
        assign out_acc = sx(y_arr[POLES-1]) + nz_x;

        always_ff @(posedge Sample_CLK) begin
            if (!Rst_n) begin
                out_q <= '0;
            end else begin
                out_q <= sat(out_acc);
            end
        end

        assign Data_out[i*DATA_W +: DATA_W] = out_q;
    end

endmodule

// File: tb/tb_channel_lpf_fx.sv
// Bench for channel_lpf_fx: three configurations share the control inputs and are scored against a cycle model.
module tb_channel_lpf_fx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  din_a;
    logic        din_b, din_c;
    logic [15:0] coef_in;
    logic        coef_wr, noise_en;

    logic [23:0] a_out;
    logic [11:0] b_out;
    logic [5:0]  c_out;
    logic        a_vld, b_vld, c_vld;
    logic        a_stb, b_stb, c_stb;
    logic        a_pnd, b_pnd, c_pnd;

    always #5 clk = ~clk;

    channel_lpf_fx #(.LANES(2), .POLES(1)) dut_a (
        .Sample_CLK(clk), .Rst_n(rst_n), .Data_in(din_a), .Coef_in(coef_in), .Coef_wr(coef_wr),
        .Noise_en(noise_en), .Data_out(a_out), .Data_valid(a_vld), .Ui_strobe(a_stb), .Coef_pend(a_pnd));

    channel_lpf_fx dut_b (
        .Sample_CLK(clk), .Rst_n(rst_n), .Data_in(din_b), .Coef_in(coef_in), .Coef_wr(coef_wr),
        .Noise_en(noise_en), .Data_out(b_out), .Data_valid(b_vld), .Ui_strobe(b_stb), .Coef_pend(b_pnd));

    channel_lpf_fx #(.DATA_W(6), .NOISE_W(3)) dut_c (
        .Sample_CLK(clk), .Rst_n(rst_n), .Data_in(din_c), .Coef_in(coef_in), .Coef_wr(coef_wr),
        .Noise_en(noise_en), .Data_out(c_out), .Data_valid(c_vld), .Ui_strobe(c_stb), .Coef_pend(c_pnd));

    typedef struct {
        int a0, a1, b0, c0;
        bit va, vb, vc;
        bit stb, pnd;
    } exp_t;

    exp_t   sb_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     dec_tbl[5] = '{0, -512, -768, -896, -960};

    // Reference state: instance k (0=a,1=b,2=c), lane i, pole p.
    int          m_phase;
    longint      m_beta, m_shadow;
    bit          m_pend;
    int          m_wcnt[3];
    bit          m_valid[3];
    longint      m_u[3][2];
    longint      m_y[3][2][2];
    longint      m_out[3][2];
    logic [15:0] m_lfsr[3][2];

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nl_of(int k); return (k == 0) ? 2 : 1; endfunction
    function automatic int np_of(int k); return (k == 0) ? 1 : 2; endfunction
    function automatic int dw_of(int k); return (k == 2) ? 6 : 12; endfunction
    function automatic int nw_of(int k); return (k == 2) ? 3 : 4; endfunction

    function automatic bit din_of(int k, int i);
        if (k == 0) return din_a[i];
        if (k == 1) return din_b;
        return din_c;
    endfunction

    function automatic longint sat_m(longint v, int dw);
        longint hi;
        hi = (longint'(1) << (dw - 1)) - 1;
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
    endfunction

    task automatic model_reset();
        logic [15:0] s;
        m_phase  = 0;
        m_beta   = 12386;
        m_shadow = 12386;
        m_pend   = 0;
        for (int k = 0; k < 3; k++) begin
            m_wcnt[k]  = 0;
            m_valid[k] = 0;
            for (int i = 0; i < 2; i++) begin
                m_u[k][i]   = 0;
                m_out[k][i] = 0;
                m_y[k][i][0] = 0;
                m_y[k][i][1] = 0;
                s = 16'hACE1 ^ 16'(i * 16'h1D3);
                m_lfsr[k][i] = (s == 16'h0000) ? 16'h0001 : s;
            end
        end
    endtask

    task automatic model_edge();
        exp_t   e;
        bit     commit;
        longint n, x, lvl;
        int     np, nw;
        if (!rst_n) begin
            model_reset();
        end else begin
            commit = (m_phase == 9);
            for (int k = 0; k < 3; k++) begin
                np  = np_of(k);
                nw  = nw_of(k);
                lvl = longint'(1) << (dw_of(k) - 2);
                for (int i = 0; i < nl_of(k); i++) begin
                    n = 0;
                    if (noise_en) begin
                        n = longint'(m_lfsr[k][i]) & ((longint'(1) << (nw + 1)) - 1);
                        if (n >= (longint'(1) << nw)) n = n - (longint'(1) << (nw + 1));
                    end
                    m_out[k][i] = sat_m(m_y[k][i][np-1] + n, dw_of(k));
                    for (int p = np - 1; p >= 0; p--) begin
                        x = (p == 0) ? m_u[k][i] : m_y[k][i][p-1];
                        m_y[k][i][p] = m_y[k][i][p] + ((m_beta * (x - m_y[k][i][p]) + 32768) >>> 16);
                    end
                    if (m_phase == 0) m_u[k][i] = din_of(k, i) ? lvl : -lvl;
                    if (noise_en)
                        m_lfsr[k][i] = {m_lfsr[k][i][14:0],
                                        m_lfsr[k][i][15] ^ m_lfsr[k][i][13] ^ m_lfsr[k][i][12] ^ m_lfsr[k][i][10]};
                end
                if (m_wcnt[k] == np) m_valid[k] = 1;
                else m_wcnt[k]++;
            end
            if (coef_wr) m_shadow = coef_in;
            if (commit) begin
                if (coef_wr) m_beta = coef_in;
                else if (m_pend) m_beta = m_shadow;
                m_pend = 0;
            end else if (coef_wr) begin
                m_pend = 1;
            end
            m_phase = (m_phase == 9) ? 0 : m_phase + 1;
        end
        e.a0 = int'(m_out[0][0]);
        e.a1 = int'(m_out[0][1]);
        e.b0 = int'(m_out[1][0]);
        e.c0 = int'(m_out[2][0]);
        e.va = m_valid[0];
        e.vb = m_valid[1];
        e.vc = m_valid[2];
        e.stb = (m_phase == 0);
        e.pnd = m_pend;
        sb_q.push_back(e);
    endtask

    task automatic sb_compare();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", 1, 0);
            return;
        end
        e = sb_q.pop_front();
        check_val("a0_out", $signed(a_out[11:0]), e.a0);
        check_val("a1_out", $signed(a_out[23:12]), e.a1);
        check_val("b0_out", $signed(b_out), e.b0);
        check_val("c0_out", $signed(c_out), e.c0);
        check_val("a_vld", a_vld, e.va);
        check_val("b_vld", b_vld, e.vb);
        check_val("c_vld", c_vld, e.vc);
        check_val("a_stb", a_stb, e.stb);
        check_val("b_stb", b_stb, e.stb);
        check_val("c_stb", c_stb, e.stb);
        check_val("a_pnd", a_pnd, e.pnd);
        check_val("b_pnd", b_pnd, e.pnd);
        check_val("c_pnd", c_pnd, e.pnd);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        sb_compare();
    endtask

    task automatic set_din(input bit v);
        din_a = {v, v};
        din_b = v;
        din_c = v;
    endtask

    task automatic run_to_phase(input int ph);
        for (int g = 0; g < 20 && m_phase != ph; g++) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_a_out"}, a_out, 0);
        check_val({tag, "_b_out"}, b_out, 0);
        check_val({tag, "_c_out"}, c_out, 0);
        check_val({tag, "_vld"}, b_vld, 0);
        check_val({tag, "_stb"}, b_stb, 1);
        check_val({tag, "_pnd"}, a_pnd, 0);
    endtask

    task automatic startup_seq();
        int b;
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check_val("warm_vld_a", a_vld, (k >= 2) ? 1 : 0);
            check_val("warm_vld_b", b_vld, (k >= 3) ? 1 : 0);
            check_val("ui_period", b_stb, (k % 10 == 0) ? 1 : 0);
        end
        repeat (250) tick();
        b = $signed(b_out);
        check_val("settle_b_win", (b >= 1018 && b <= 1024) ? 1 : 0, 1);
    endtask

    initial begin
        int v, diffs;
        rst_n    = 1'b0;
        coef_in  = '0;
        coef_wr  = 1'b0;
        noise_en = 1'b0;
        set_din(1'b1);
        tick();
        tick();
        check_reset_outputs("rst0");
        startup_seq();

        // Mid-UI glitch on Data_in must be ignored.
        run_to_phase(4);
        set_din(1'b0);
        tick();
        set_din(1'b1);
        repeat (20) tick();

        // Pending write at phase 3, overwritten at phase 5, committed on phase 9.
        run_to_phase(3);
        coef_in = 16'd1000;
        coef_wr = 1'b1;
        tick();
        coef_wr = 1'b0;
        while (m_phase != 9) begin
            check_val("pend_hold", a_pnd, 1);
            if (m_phase == 5) begin
                coef_in = 16'd20000;
                coef_wr = 1'b1;
            end
            tick();
            coef_wr = 1'b0;
        end
        check_val("pend_at9", a_pnd, 1);
        tick();
        check_val("pend_commit", a_pnd, 0);
        repeat (40) tick();

        // Write landing on a commit edge takes effect directly.
        run_to_phase(9);
        coef_in = 16'd32768;
        coef_wr = 1'b1;
        tick();
        coef_wr = 1'b0;
        check_val("pend_direct", a_pnd, 0);
        repeat (100) tick();
        check_val("half_a0", $signed(a_out[11:0]), 1024);
        check_val("half_a1", $signed(a_out[23:12]), 1024);
        check_val("half_c0", $signed(c_out), 16);

        run_to_phase(0);
        set_din(1'b0);
        tick();
        tick();
        for (int j = 0; j < 5; j++) begin
            tick();
            check_val("decay_a0", $signed(a_out[11:0]), dec_tbl[j]);
        end
        repeat (60) tick();
        v = $signed(a_out[11:0]);
        check_val("low_a0_win", (v >= -1024 && v <= -1023) ? 1 : 0, 1);

        set_din(1'b1);
        repeat (60) tick();
        noise_en = 1'b1;
        diffs = 0;
        for (int j = 0; j < 80; j++) begin
            tick();
            v = $signed(a_out[11:0]) - 1024;
            check_val("noise_a0_win", (v >= -16 && v <= 15) ? 1 : 0, 1);
            v = $signed(c_out);
            check_val("noise_c0_win", (v >= 8 && v <= 23) ? 1 : 0, 1);
            if (a_out[11:0] != a_out[23:12]) diffs++;
        end
        check_val("lanes_differ", (diffs > 0) ? 1 : 0, 1);

        // One reset edge in the middle of a transition with a write pending.
        noise_en = 1'b0;
        run_to_phase(0);
        set_din(1'b0);
        coef_in = 16'd5;
        coef_wr = 1'b1;
        tick();
        coef_wr = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        set_din(1'b1);
        tick();
        check_reset_outputs("rst1");
        startup_seq();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
